// File: rtl/sample_streamer.sv
// sample_streamer: walks the sample ROM, prefetches words into a small FIFO at full
// clock rate and releases one sample per TICK_DIV clocks to the PWM stage over a
// valid/ready handshake. Underrun and overrun are reported as sticky flags.
//
// Optional feature macro: SAMPLE_LOOP_EN
//   defined   - fetch wraps from LAST_ADDR back to 0, clip plays until aud_en drops
//   undefined - one-shot clip: fetch stops after LAST_ADDR, done pulses once drained
//
// Ports:
//   clk        sole clock
//   rst        synchronous active-high reset
//   aud_en     play enable (level, synchronous)
//   rom_addr   ROM read address (combinational ROM)
//   rom_data   ROM read data for rom_addr
//   smp_data   FIFO head offered to the PWM stage
//   smp_valid  sample offered
//   smp_ready  PWM stage accepts
//   playing    high while filling or playing
//   done       one-cycle pulse at the end of a one-shot clip
//   underrun   sticky: tick with FIFO empty
//   overrun    sticky: tick while previous sample still pending
module sample_streamer #(
    parameter int unsigned        ADDR_W    = 16,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        TICK_DIV  = 1024,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [ADDR_W-1:0]  LAST_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aud_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              playing,
    output logic              done,
    output logic              underrun,
    output logic              overrun
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned TickW = $clog2(TICK_DIV);

    localparam logic [CntW-1:0]  FullCnt  = CntW'(DEPTH);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StFill, StPlay} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic [TickW-1:0]   tick_cnt_q;
    logic               pending_q;
    logic               fetch_done_q;
    logic               underrun_q, overrun_q, done_q;
    // Set by a finished one-shot clip; aud_en must be seen low before the next start.
    logic               rearm_q;

    logic               in_play, fifo_empty, fifo_full;
    logic               xfer, push, tick, wrap_addr;
    logic [CntW-1:0]    count_after_pop, count_next;
    logic               pending_next, fetch_done_next;
    logic               under_set, over_set, clip_end;

    always_comb begin
        in_play    = (state_q == StPlay);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FullCnt);
        // Gated by aud_en so nothing transfers in the cycle play is withdrawn.
        smp_valid  = in_play && aud_en && pending_q && !fifo_empty;
        xfer       = smp_valid && smp_ready;
        push       = (state_q != StIdle) && aud_en && !fifo_full && !fetch_done_q;
        tick       = in_play && aud_en && (tick_cnt_q == TickLast);
        wrap_addr  = (addr_q == LAST_ADDR);

        count_after_pop = count_q - CntW'(xfer);
        count_next      = count_after_pop + CntW'(push);

        // A tick that lands on the cycle the pending sample is taken is not an overrun.
        pending_next = pending_q && !xfer;
        under_set    = 1'b0;
        over_set     = 1'b0;
        if (tick) begin
            if (count_after_pop == '0) begin
                under_set = 1'b1;
            end else begin
                over_set     = pending_next;
                pending_next = 1'b1;
            end
        end

`ifdef SAMPLE_LOOP_EN
        fetch_done_next = 1'b0;
        clip_end        = 1'b0;
`else
        fetch_done_next = fetch_done_q || (push && wrap_addr);
        clip_end        = in_play && fetch_done_next && (count_next == '0) && !pending_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tick_cnt_q   <= '0;
            pending_q    <= 1'b0;
            fetch_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
            rearm_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!aud_en) begin
                        rearm_q <= 1'b0;
                    end else if (!rearm_q) begin
                        state_q    <= StFill;
                        underrun_q <= 1'b0;
                        overrun_q  <= 1'b0;
                    end
                end
                StFill, StPlay: begin
                    if (!aud_en) begin
                        state_q      <= StIdle;
                        addr_q       <= '0;
                        wr_ptr_q     <= '0;
                        rd_ptr_q     <= '0;
                        count_q      <= '0;
                        tick_cnt_q   <= '0;
                        pending_q    <= 1'b0;
                        fetch_done_q <= 1'b0;
                    end else begin
                        if (push) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            addr_q   <= wrap_addr ? '0 : addr_q + 1'b1;
                        end
                        if (xfer) begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                        count_q      <= count_next;
                        pending_q    <= pending_next;
                        fetch_done_q <= fetch_done_next;
                        if (under_set) underrun_q <= 1'b1;
                        if (over_set)  overrun_q  <= 1'b1;

                        if (state_q == StFill) begin
                            // A clip shorter than the FIFO starts playing once fully fetched.
                            if ((count_next == FullCnt) || fetch_done_next) begin
                                state_q <= StPlay;
                            end
                        end else begin
                            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
                            if (clip_end) begin
                                state_q      <= StIdle;
                                done_q       <= 1'b1;
                                rearm_q      <= 1'b1;
                                addr_q       <= '0;
                                tick_cnt_q   <= '0;
                                fetch_done_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rom_addr = addr_q;
    assign smp_data = fifo_empty ? '0 : mem[rd_ptr_q];
    assign playing  = (state_q != StIdle);
    assign done     = done_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Self-checking bench for sample_streamer: directed scenarios with spec-derived
// expectations plus a randomized run checked against a queue-based reference model.
module tb_sample_streamer;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TICK_DIV  = 6;
    localparam int unsigned DEPTH     = 4;
    localparam logic [15:0] LAST_ADDR = 16'd5;
`ifdef SAMPLE_LOOP_EN
    localparam bit Loop = 1'b1;
`else
    localparam bit Loop = 1'b0;
`endif

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    logic              clk = 1'b0;
    logic              rst, aud_en, smp_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data, smp_data;
    logic              smp_valid, playing, done, underrun, overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_word(rom_addr);

    sample_streamer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TICK_DIV (TICK_DIV),
        .DEPTH    (DEPTH),
        .LAST_ADDR(LAST_ADDR)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .aud_en   (aud_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .smp_data (smp_data),
        .smp_valid(smp_valid),
        .smp_ready(smp_ready),
        .playing  (playing),
        .done     (done),
        .underrun (underrun),
        .overrun  (overrun)
    );

    // Reference model: FIFO as a queue, sample period from cycles spent playing.
    int          m_st;        // 0 idle, 1 fill, 2 play
    logic [15:0] m_addr;
    logic [31:0] m_q[$];
    bit          m_pend, m_fdone, m_under, m_over, m_done, m_need_low;
    int          m_play_cyc;

    task automatic model_reset();
        m_st = 0; m_addr = '0; m_q.delete(); m_pend = 0; m_fdone = 0;
        m_under = 0; m_over = 0; m_done = 0; m_need_low = 0; m_play_cyc = 0;
    endtask

    task automatic model_step(input bit en, input bit rdy);
        bit valid, xfer, tick, push;
        valid  = (m_st == 2) && en && m_pend && (m_q.size() > 0);
        m_done = 0;
        if (m_st == 0) begin
            if (!en) m_need_low = 0;
            else if (!m_need_low) begin
                m_st = 1; m_under = 0; m_over = 0; m_addr = '0; m_fdone = 0;
            end
        end else if (!en) begin
            m_st = 0; m_q.delete(); m_addr = '0; m_pend = 0; m_fdone = 0;
        end else begin
            xfer = valid && rdy;
            tick = (m_st == 2) && ((m_play_cyc % TICK_DIV) == TICK_DIV - 1);
            push = (m_q.size() < DEPTH) && !m_fdone;
            if (xfer) begin
                void'(m_q.pop_front());
                m_pend = 0;
            end
            if (tick) begin
                if (m_q.size() == 0) m_under = 1;
                else begin
                    if (m_pend) m_over = 1;
                    m_pend = 1;
                end
            end
            if (push) begin
                m_q.push_back(rom_word(m_addr));
                if (m_addr == LAST_ADDR && !Loop) m_fdone = 1;
                m_addr = (m_addr == LAST_ADDR) ? 16'd0 : m_addr + 16'd1;
            end
            if (m_st == 1) begin
                if (m_q.size() == DEPTH || m_fdone) begin
                    m_st = 2; m_play_cyc = 0;
                end
            end else begin
                m_play_cyc++;
                if (!Loop && m_fdone && m_q.size() == 0 && !m_pend) begin
                    m_st = 0; m_done = 1; m_need_low = 1; m_addr = '0;
                end
            end
        end
    endtask

    // Leaves the bench just after a clock edge, DUT idle, in "cycle 0".
    task automatic do_reset();
        rst = 1'b1; aud_en = 1'b0; smp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; aud_en = 1'b1; smp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (rom_addr !== 16'd0) begin n_err++; $display("FAIL reset rom_addr got %h want 0", rom_addr); end
        n_vec++; if (smp_data !== 32'd0) begin n_err++; $display("FAIL reset smp_data got %h want 0", smp_data); end
        n_vec++; if (smp_valid !== 1'b0) begin n_err++; $display("FAIL reset smp_valid got %b want 0", smp_valid); end
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL reset playing got %b want 0", playing); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got %b want 0", done); end
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset underrun got %b want 0", underrun); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset overrun got %b want 0", overrun); end
        rst = 1'b0; aud_en = 1'b0;
    endtask

    task automatic test_fill_play();
        int nx = 0;
        do_reset();
        aud_en = 1'b1; smp_ready = 1'b1;
        for (int c = 1; c <= int'(DEPTH + 1 + 3 * TICK_DIV); c++) begin
            @(posedge clk); @(negedge clk);
            if (c <= int'(DEPTH)) begin
                n_vec++; if (rom_addr !== 16'(c - 1)) begin n_err++; $display("FAIL fill rom_addr cycle %0d got %0d want %0d", c, rom_addr, c - 1); end
                n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL fill playing cycle %0d got %b want 1", c, playing); end
            end else if (c <= int'(DEPTH + 1 + TICK_DIV)) begin
                n_vec++; if (rom_addr !== 16'(DEPTH)) begin n_err++; $display("FAIL full_hold rom_addr cycle %0d got %0d want %0d", c, rom_addr, DEPTH); end
            end
            if (smp_valid === 1'b1) begin
                n_vec++; if (c != int'(DEPTH + 1 + TICK_DIV * (nx + 1))) begin n_err++; $display("FAIL sample_time #%0d at cycle %0d want %0d", nx, c, DEPTH + 1 + TICK_DIV * (nx + 1)); end
                n_vec++; if (smp_data !== rom_word(16'(nx))) begin n_err++; $display("FAIL sample_data #%0d got %h want %h", nx, smp_data, rom_word(16'(nx))); end
                nx++;
            end
        end
        n_vec++; if (nx != 3) begin n_err++; $display("FAIL sample_count got %0d want 3", nx); end
        n_vec++; if (underrun !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL stream_flags got u=%b o=%b want 0 0", underrun, overrun); end
    endtask

    task automatic test_overrun();
        int nx = 0;
        do_reset();
        aud_en = 1'b1; smp_ready = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            smp_ready = (c == 18 || c == 23);
            @(negedge clk);
            if (c == 16) begin
                n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_early got %b want 0", overrun); end
            end
            if (c == 17) begin
                n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set got %b want 1", overrun); end
            end
            if (c == 18) begin
                n_vec++; if (smp_valid !== 1'b1) begin n_err++; $display("FAIL overrun_valid got %b want 1", smp_valid); end
                n_vec++; if (smp_data !== rom_word(16'd0)) begin n_err++; $display("FAIL overrun_data got %h want %h", smp_data, rom_word(16'd0)); end
            end
            if (c == 19) begin
                n_vec++; if (smp_valid !== 1'b0) begin n_err++; $display("FAIL overrun_dup got valid %b want 0", smp_valid); end
            end
            if (c == 23) begin
                n_vec++; if (smp_valid !== 1'b1 || smp_data !== rom_word(16'd1)) begin n_err++; $display("FAIL overrun_next got v=%b d=%h want 1 %h", smp_valid, smp_data, rom_word(16'd1)); end
            end
            if (smp_valid === 1'b1 && smp_ready === 1'b1) nx++;
        end
        n_vec++; if (nx != 2) begin n_err++; $display("FAIL overrun_xfers got %0d want 2", nx); end
        n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL overrun_underrun got %b want 0", underrun); end
        smp_ready = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [31:0] got[$];
        int last_x = -1, done_c = -1, n_done = 0;
        bit idle_at_done = 0;
        do_reset();
        aud_en = 1'b1; smp_ready = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); @(negedge clk);
            if (smp_valid === 1'b1) begin got.push_back(smp_data); last_x = c; end
            if (done === 1'b1) begin
                n_done++;
                if (done_c < 0) begin done_c = c; idle_at_done = (playing === 1'b0); end
            end
        end
`ifdef SAMPLE_LOOP_EN
        n_vec++; if (got.size() < 8) begin n_err++; $display("FAIL loop_count got %0d want >=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_vec++; if (got[i] !== rom_word(16'(i % (int'(LAST_ADDR) + 1)))) begin n_err++; $display("FAIL loop_data #%0d got %h want %h", i, got[i], rom_word(16'(i % (int'(LAST_ADDR) + 1)))); end
        end
        n_vec++; if (n_done != 0) begin n_err++; $display("FAIL loop_done got %0d pulses want 0", n_done); end
        n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL loop_playing got %b want 1", playing); end
`else
        n_vec++; if (got.size() != int'(LAST_ADDR) + 1) begin n_err++; $display("FAIL oneshot_count got %0d want %0d", got.size(), int'(LAST_ADDR) + 1); end
        for (int i = 0; i < got.size(); i++) begin
            n_vec++; if (got[i] !== rom_word(16'(i))) begin n_err++; $display("FAIL oneshot_data #%0d got %h want %h", i, got[i], rom_word(16'(i))); end
        end
        n_vec++; if (n_done != 1) begin n_err++; $display("FAIL oneshot_done_pulses got %0d want 1", n_done); end
        n_vec++; if (done_c != last_x + 1) begin n_err++; $display("FAIL oneshot_done_time got %0d want %0d", done_c, last_x + 1); end
        n_vec++; if (!idle_at_done) begin n_err++; $display("FAIL oneshot_idle_at_done got playing=1 want 0"); end
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL oneshot_no_restart got playing=%b want 0", playing); end
`endif
        aud_en = 1'b0; smp_ready = 1'b0;
    endtask

    task automatic test_drop();
        int c;
        do_reset();
        aud_en = 1'b1; smp_ready = 1'b0;
        for (c = 0; c < 40 && overrun !== 1'b1; c++) begin
            @(posedge clk); @(negedge clk);
        end
        n_vec++; if (overrun !== 1'b1 || smp_valid !== 1'b1) begin n_err++; $display("FAIL drop_setup got o=%b v=%b want 1 1", overrun, smp_valid); end
        @(posedge clk); #1; aud_en = 1'b0; smp_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (smp_valid !== 1'b0) begin n_err++; $display("FAIL drop_gate got valid %b want 0", smp_valid); end
        @(posedge clk); #1; aud_en = 1'b1;
        @(negedge clk);
        n_vec++; if (smp_valid !== 1'b0 || rom_addr !== 16'd0 || playing !== 1'b0) begin n_err++; $display("FAIL drop_idle got v=%b a=%0d p=%b want 0 0 0", smp_valid, rom_addr, playing); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL drop_sticky got overrun %b want 1", overrun); end
        @(posedge clk); @(negedge clk);
        n_vec++; if (playing !== 1'b1 || rom_addr !== 16'd0) begin n_err++; $display("FAIL refill_start got p=%b a=%0d want 1 0", playing, rom_addr); end
        n_vec++; if (overrun !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL refill_flags got o=%b u=%b want 0 0", overrun, underrun); end
        for (c = 0; c < 30 && smp_valid !== 1'b1; c++) begin
            @(posedge clk); @(negedge clk);
        end
        n_vec++; if (smp_valid !== 1'b1 || smp_data !== rom_word(16'd0)) begin n_err++; $display("FAIL refill_first got v=%b d=%h want 1 %h", smp_valid, smp_data, rom_word(16'd0)); end
        aud_en = 1'b0; smp_ready = 1'b0;
    endtask

    task automatic test_rst_mid_fill();
        do_reset();
        aud_en = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_vec++; if (playing !== 1'b1 || rom_addr !== 16'd1) begin n_err++; $display("FAIL midfill_setup got p=%b a=%0d want 1 1", playing, rom_addr); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_vec++; if (rom_addr !== 16'd0 || smp_data !== 32'd0 || smp_valid !== 1'b0 || playing !== 1'b0 ||
                     done !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL midfill_reset got a=%0d d=%h v=%b p=%b dn=%b u=%b o=%b want all 0",
                     rom_addr, smp_data, smp_valid, playing, done, underrun, overrun);
        end
        rst = 1'b0; aud_en = 1'b0;
    endtask

    task automatic test_random();
        int pct = 50;
        bit exp_valid;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 5;
                    1: pct = 30;
                    2: pct = 70;
                    default: pct = 100;
                endcase
            end
            aud_en    = ($urandom_range(0, 149) != 0);
            smp_ready = ($urandom_range(1, 100) <= pct);
            @(negedge clk);
            exp_valid = (m_st == 2) && aud_en && m_pend && (m_q.size() > 0);
            n_vec++; if (rom_addr !== m_addr) begin n_err++; $display("FAIL rand_rom_addr c=%0d got %0d want %0d", c, rom_addr, m_addr); end
            n_vec++; if (smp_valid !== exp_valid) begin n_err++; $display("FAIL rand_valid c=%0d got %b want %b", c, smp_valid, exp_valid); end
            if (exp_valid) begin
                n_vec++; if (smp_data !== m_q[0]) begin n_err++; $display("FAIL rand_data c=%0d got %h want %h", c, smp_data, m_q[0]); end
            end
            n_vec++; if (playing !== (m_st != 0)) begin n_err++; $display("FAIL rand_playing c=%0d got %b want %b", c, playing, m_st != 0); end
            n_vec++; if (done !== m_done) begin n_err++; $display("FAIL rand_done c=%0d got %b want %b", c, done, m_done); end
            n_vec++; if (underrun !== m_under) begin n_err++; $display("FAIL rand_underrun c=%0d got %b want %b", c, underrun, m_under); end
            n_vec++; if (overrun !== m_over) begin n_err++; $display("FAIL rand_overrun c=%0d got %b want %b", c, overrun, m_over); end
            model_step(aud_en, smp_ready);
            @(posedge clk); #1;
        end
        aud_en = 1'b0; smp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; aud_en = 1'b0; smp_ready = 1'b0;
        test_reset();
        test_fill_play();
        test_overrun();
        test_oneshot();
        test_drop();
        test_rst_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
